// File: rtl/ram_port_scheduler_if.sv
// Requester-side channel of ram_port_scheduler: per-requester valid/ready
// command lanes, read-response strobes and the current grant.
interface ram_port_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wrdata;
    logic [NUM_REQ-1:0]            req_rdwrn;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rddata;
    logic [NUM_REQ-1:0]            grant;

    modport master (
        output req_valid, req_addr, req_wrdata, req_rdwrn,
        input  req_ready, rsp_valid, rsp_rddata, grant
    );

    modport slave (
        input  req_valid, req_addr, req_wrdata, req_rdwrn,
        output req_ready, rsp_valid, rsp_rddata, grant
    );
endinterface

// File: rtl/ram_port_scheduler.sv
// Round-robin, burst-limited scheduler sharing one single-port RAM among NUM_REQ requesters.
// Define RAM_SCHED_PRIO0_EN to give requester 0 absolute priority at every arbitration point.
module ram_port_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_port_scheduler_if.slave   bus,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wrdata,
    output logic                  ram_rdwrn,
    input  logic [DATA_WIDTH-1:0] ram_rddata
);
    localparam int OW  = $clog2(NUM_REQ);
    localparam int BCW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state;
    logic [OW-1:0]        owner;
    logic [OW-1:0]        last_owner;
    logic [OW-1:0]        cmd_owner;
    logic [BCW-1:0]       beat_cnt;
    logic [NUM_REQ-1:0]   grant_q;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wrdata;
    logic                  sel_rdwrn;
    logic                  own_valid;
    logic                  accept;
    logic                  burst_end;
    logic                  found;
    logic [OW-1:0]         winner;

    logic [RD_LATENCY-1:0] tag_v;
    logic [OW-1:0]         tag_o [RD_LATENCY];
    logic [NUM_REQ-1:0]    rsp_v;

    always_comb begin
        sel_addr   = '0;
        sel_wrdata = '0;
        sel_rdwrn  = 1'b1;
        own_valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == OW'(i)) begin
                sel_addr   = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wrdata = bus.req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_rdwrn  = bus.req_rdwrn[i];
                own_valid  = bus.req_valid[i];
            end
        end
    end

    assign accept    = (state == GRANT) && own_valid;
    assign burst_end = (state == GRANT) && (!own_valid || (beat_cnt == BCW'(BURST_MAX - 1)));

    // Search starts just after last_owner, so the current owner comes last.
    always_comb begin
        int j;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last_owner) + k) % NUM_REQ;
            if (!found && bus.req_valid[j]) begin
                found  = 1'b1;
                winner = OW'(j);
            end
        end
`ifdef RAM_SCHED_PRIO0_EN
        if (bus.req_valid[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            grant_q    <= '0;
            cmd_owner  <= '0;
            ram_en     <= 1'b0;
            ram_addr   <= '0;
            ram_wrdata <= '0;
            ram_rdwrn  <= 1'b1;
        end else begin
            ram_en <= accept;
            if (accept) begin
                ram_addr   <= sel_addr;
                ram_wrdata <= sel_wrdata;
                ram_rdwrn  <= sel_rdwrn;
                cmd_owner  <= owner;
            end
            if ((state == IDLE) || burst_end) begin
                if (found) begin
                    state    <= GRANT;
                    owner    <= winner;
                    grant_q  <= NUM_REQ'(1) << winner;
                    beat_cnt <= '0;
`ifdef RAM_SCHED_PRIO0_EN
                    if (winner != '0)
                        last_owner <= winner;
`else
                    last_owner <= winner;
`endif
                end else begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Owner tags travel alongside reads so returning data reaches the issuer.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            for (int k = 0; k < RD_LATENCY; k++) tag_o[k] <= '0;
        end else begin
            tag_v[0] <= ram_en && ram_rdwrn;
            tag_o[0] <= cmd_owner;
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_o[k] <= tag_o[k-1];
            end
        end
    end

    always_comb begin
        rsp_v = '0;
        if (tag_v[RD_LATENCY-1])
            rsp_v[tag_o[RD_LATENCY-1]] = 1'b1;
    end

    assign bus.req_ready  = grant_q;
    assign bus.grant      = grant_q;
    assign bus.rsp_valid  = rsp_v;
    assign bus.rsp_rddata = ram_rddata;
endmodule
